// File: rtl/alu_pkg.sv
// Shared constants for the ALU / branch unit:
// control codes, main-control op classes and R-type funct values.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // Map an R-type funct field to its control code;
  // unknown encodings fall back to ADD.
  function automatic logic [3:0] funct_to_ctrl(
    input logic [5:0] fn
  );
    logic [3:0] c;
    c = ALU_ADD;
    case (fn)
      FN_ADD:  c = ALU_ADD;
      FN_SUB:  c = ALU_SUB;
      FN_AND:  c = ALU_AND;
      FN_OR:   c = ALU_OR;
      FN_SLT:  c = ALU_SLT;
      FN_NOR:  c = ALU_NOR;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: main-control op class plus
// funct field to a 4-bit ALU control code.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl
);

  // Op class selects a fixed code; R-type defers to funct.
  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      OP_ADD:   alu_ctrl = ALU_ADD;
      OP_SUB:   alu_ctrl = ALU_SUB;
      OP_OR:    alu_ctrl = ALU_OR;
      OP_RTYPE: alu_ctrl = funct_to_ctrl(funct);
    endcase
  end

endmodule

// File: rtl/alu_branch_unit.sv
// ALU with registered result, zero flag and branch-taken
// flag; control decode is combinational and reset-free.
module alu_branch_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             branch,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             pc_src
);

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             pc_src_d, pc_src_q;
  logic             slt;

  alu_ctrl_dec u_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (alu_ctrl)
  );

  // Datapath: evaluate the selected operation; add/sub wrap.
  always_comb begin
    slt      = $signed(a) < $signed(b);
    result_d = '0;
    case (alu_ctrl)
      ALU_AND: result_d = a & b;
      ALU_OR:  result_d = a | b;
      ALU_ADD: result_d = a + b;
      ALU_SUB: result_d = a - b;
      ALU_SLT: result_d = {{(WIDTH-1){1'b0}}, slt};
      ALU_NOR: result_d = ~(a | b);
      default: result_d = '0;
    endcase
    zero_d   = (result_d == '0);
    pc_src_d = branch & zero_d;
  end

  // Output registers; reset discards any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      pc_src_q <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      pc_src_q <= pc_src_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign pc_src = pc_src_q;

endmodule

// File: tb/tb_alu_branch_unit.sv
// Bench for alu_branch_unit: directed cases, reset
// behaviour and random stimulus against a reference model.
module tb_alu_branch_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic        branch;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        pc_src;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_r;
  logic        exp_z;
  logic        exp_p;

  alu_branch_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_op   (alu_op),
    .funct    (funct),
    .a        (a),
    .b        (b),
    .branch   (branch),
    .alu_ctrl (alu_ctrl),
    .result   (result),
    .zero     (zero),
    .pc_src   (pc_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: operation name from op class / funct.
  // 0=add 1=sub 2=and 3=or 4=slt 5=nor
  function automatic int ref_kind(
    input logic [1:0] op, input logic [5:0] fn
  );
    if (op == 2'b00) return 0;
    if (op == 2'b01) return 1;
    if (op == 2'b11) return 3;
    case (fn)
      6'h20: return 0;
      6'h22: return 1;
      6'h24: return 2;
      6'h25: return 3;
      6'h2a: return 4;
      6'h27: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] ref_code(input int k);
    case (k)
      0: return 4'b0010;
      1: return 4'b0110;
      2: return 4'b0000;
      3: return 4'b0001;
      4: return 4'b0111;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic logic [31:0] ref_res(
    input int k, input logic [31:0] x, input logic [31:0] y
  );
    longint s;
    logic [63:0] w;
    case (k)
      0: s = longint'(x) + longint'(y);
      1: s = longint'(x) - longint'(y);
      2: s = longint'(x & y);
      3: s = longint'(x | y);
      4: s = (int'(x) < int'(y)) ? 64'd1 : 64'd0;
      default: s = longint'(~(x | y));
    endcase
    w = s;
    return w[31:0];
  endfunction

  task automatic chk(
    input string tag, input logic [31:0] obs, input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operation, check decode and 1-cycle latency.
  task automatic run(
    input logic [1:0] op, input logic [5:0] fn,
    input logic [31:0] x, input logic [31:0] y, input logic br
  );
    int k;
    @(negedge clk);
    alu_op = op; funct = fn; a = x; b = y; branch = br;
    k = ref_kind(op, fn);
    #1;
    chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, ref_code(k)});
    chk("hold_result", result, exp_r);
    exp_r = ref_res(k, x, y);
    exp_z = (exp_r == 32'd0);
    exp_p = br && exp_z;
    @(posedge clk);
    #1;
    chk("result", result, exp_r);
    chk("zero", {31'd0, zero}, {31'd0, exp_z});
    chk("pc_src", {31'd0, pc_src}, {31'd0, exp_p});
  endtask

  initial begin
    rst = 1'b0; alu_op = 2'b01; funct = 6'd0;
    a = 32'd5; b = 32'd5; branch = 1'b1;
    exp_r = 32'd0; exp_z = 1'b0; exp_p = 1'b0;

    // Reset asserted before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_pc_src", {31'd0, pc_src}, 32'd0);
    chk("rst_ctrl", {28'd0, alu_ctrl}, 32'h6);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk_result", result, 32'd0);
    chk("rst_clk_zero", {31'd0, zero}, 32'd0);
    chk("rst_clk_pc_src", {31'd0, pc_src}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // R-type sweep.
    run(2'b10, 6'b100000, 32'hC, 32'hA, 1'b0);
    chk("sweep_add", result, 32'h16);
    run(2'b10, 6'b100010, 32'hC, 32'hA, 1'b0);
    chk("sweep_sub", result, 32'h2);
    run(2'b10, 6'b100100, 32'hC, 32'hA, 1'b0);
    chk("sweep_and", result, 32'h8);
    run(2'b10, 6'b100101, 32'hC, 32'hA, 1'b0);
    chk("sweep_or", result, 32'hE);
    run(2'b10, 6'b100111, 32'hC, 32'hA, 1'b0);
    chk("sweep_nor", result, 32'hFFFFFFF1);

    // Signed set-less-than.
    run(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1, 1'b0);
    chk("slt_neg", result, 32'h1);
    run(2'b10, 6'b101010, 32'h1, 32'hFFFFFFFF, 1'b0);
    chk("slt_pos", result, 32'h0);

    // Branch equal / not equal / disabled.
    run(2'b01, 6'd0, 32'h1234, 32'h1234, 1'b1);
    chk("beq_pc_src", {31'd0, pc_src}, 32'd1);
    run(2'b01, 6'd0, 32'h1235, 32'h1234, 1'b1);
    chk("bne_pc_src", {31'd0, pc_src}, 32'd0);
    run(2'b01, 6'd0, 32'h77, 32'h77, 1'b0);
    chk("bdis_zero", {31'd0, zero}, 32'd1);
    chk("bdis_pc_src", {31'd0, pc_src}, 32'd0);

    // Wrap-around add and default funct decode.
    run(2'b00, 6'd0, 32'hFFFFFFFF, 32'h1, 1'b0);
    chk("wrap_zero", {31'd0, zero}, 32'd1);
    run(2'b10, 6'b000000, 32'h3, 32'h4, 1'b0);
    chk("dflt_ctrl", {28'd0, alu_ctrl}, 32'h2);
    run(2'b11, 6'd0, 32'hF0, 32'h0F, 1'b1);

    // Mid-operation reset discards the pending result.
    @(negedge clk);
    alu_op = 2'b00; a = 32'h10; b = 32'h20; branch = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_result", result, 32'h30);
    exp_r = 32'h30;

    // Random stimulus against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [31:0] x;
      logic [31:0] y;
      logic [5:0]  fns [6];
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
      else fn = fns[$urandom_range(0, 5)];
      x = $urandom;
      if ($urandom_range(0, 1) == 1) x = x & 32'h8000000F;
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = ~x;
        default: y = $urandom;
      endcase
      run(op, fn, x, y, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
